// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: sequences core reset, counts RUN cycles,
// declares halt when the PC sticks and stops the run at a cycle limit.
module mips_run_ctrl #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 25,
    parameter int unsigned HALT_REPEAT  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_valid,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic                 halted,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [PC_WIDTH-1:0]  halt_pc
);

    localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned SC_W  = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST_CORE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
    logic [SC_W-1:0]      same_cnt_q, same_cnt_d;
    logic [PC_WIDTH-1:0]  halt_pc_q, halt_pc_d;
    logic                 core_reset_q, core_reset_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 halted_q, halted_d;
    logic                 timeout_q, timeout_d;

    logic                 pc_repeat;
    logic                 halt_evt;
    logic                 limit_evt;

    // Event decode: a valid sample repeating the tracked PC, and the cycle limit.
    assign pc_repeat = pc_valid && (same_cnt_q != '0) && (pc == last_pc_q);
    assign halt_evt  = pc_repeat && (same_cnt_q >= SC_W'(HALT_REPEAT - 1));
    assign limit_evt = (cycle_count_q == CNT_WIDTH'(MAX_CYCLES));

    // State and output registers; reset aborts any run and drops all flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            last_pc_q     <= '0;
            same_cnt_q    <= '0;
            halt_pc_q     <= '0;
            core_reset_q  <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            last_pc_q     <= last_pc_d;
            same_cnt_q    <= same_cnt_d;
            halt_pc_q     <= halt_pc_d;
            core_reset_q  <= core_reset_d;
            running_q     <= running_d;
            done_q        <= done_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        last_pc_d     = last_pc_q;
        same_cnt_d    = same_cnt_q;
        halt_pc_d     = halt_pc_q;
        core_reset_d  = core_reset_q;
        running_d     = running_q;
        done_d        = done_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                core_reset_d = 1'b1;
                running_d    = 1'b0;
                if (start) begin
                    state_d       = S_RST_CORE;
                    rst_cnt_d     = RST_W'(RESET_CYCLES - 1);
                    cycle_count_d = '0;
                    halt_pc_d     = '0;
                    done_d        = 1'b0;
                    halted_d      = 1'b0;
                    timeout_d     = 1'b0;
                end
            end

            S_RST_CORE: begin
                core_reset_d = 1'b1;
                running_d    = 1'b0;
                if (rst_cnt_q == '0) begin
                    state_d       = S_RUN;
                    core_reset_d  = 1'b0;
                    running_d     = 1'b1;
                    cycle_count_d = CNT_WIDTH'(1);
                    same_cnt_d    = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end

            S_RUN: begin
                core_reset_d = 1'b0;
                running_d    = 1'b1;
                // Track the PC run length; invalid samples leave the tracker untouched.
                if (pc_valid) begin
                    if (!pc_repeat) begin
                        last_pc_d  = pc;
                        same_cnt_d = SC_W'(1);
                    end else if (same_cnt_q != SC_W'(HALT_REPEAT)) begin
                        same_cnt_d = same_cnt_q + SC_W'(1);
                    end
                end
                // Halt wins over the cycle limit when both land in the same cycle.
                if (halt_evt) begin
                    state_d      = S_DONE;
                    core_reset_d = 1'b1;
                    running_d    = 1'b0;
                    done_d       = 1'b1;
                    halted_d     = 1'b1;
                    halt_pc_d    = pc;
                end else if (limit_evt) begin
                    state_d      = S_DONE;
                    core_reset_d = 1'b1;
                    running_d    = 1'b0;
                    done_d       = 1'b1;
                    timeout_d    = 1'b1;
                end else begin
                    cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: stimulus queues expected output snapshots
// stamped with a cycle number; the monitor compares them on the falling edge.
module tb_mips_run_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        pc_valid;
    logic        core_reset;
    logic        running;
    logic        done;
    logic        halted;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] halt_pc;

    typedef struct packed {
        logic        cr;
        logic        run;
        logic        dn;
        logic        hl;
        logic        to;
        logic [31:0] cc;
        logic [31:0] hpc;
    } obs_t;

    obs_t  exp_q[$];
    int    stamp_q[$];
    string name_q[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    mips_run_ctrl #(
        .PC_WIDTH    (32),
        .CNT_WIDTH   (32),
        .RESET_CYCLES(4),
        .MAX_CYCLES  (25),
        .HALT_REPEAT (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .halted     (halted),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .halt_pc    (halt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        int    s;
        string n;
        a = '{cr: core_reset, run: running, dn: done, hl: halted, to: timeout,
              cc: cycle_count, hpc: halt_pc};
        while (stamp_q.size() > 0 && stamp_q[0] <= cyc) begin
            e = exp_q.pop_front();
            s = stamp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (s < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", n, s, cyc);
            end else if (a !== e) begin
                errors++;
                $display("FAIL %s @%0d: got cr=%b run=%b done=%b halt=%b to=%b cc=%0d hpc=%h, want cr=%b run=%b done=%b halt=%b to=%b cc=%0d hpc=%h",
                         n, cyc, a.cr, a.run, a.dn, a.hl, a.to, a.cc, a.hpc,
                         e.cr, e.run, e.dn, e.hl, e.to, e.cc, e.hpc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic cr, input logic run,
                              input logic dn, input logic hl, input logic to,
                              input int cc, input logic [31:0] hpc);
        obs_t e;
        e = '{cr: cr, run: run, dn: dn, hl: hl, to: to, cc: 32'(cc), hpc: hpc};
        exp_q.push_back(e);
        stamp_q.push_back(cyc);
        name_q.push_back(nm);
    endtask

    // Start pulse, four core-reset cycles, then the first RUN cycle.
    task automatic start_run();
        start    = 1'b1;
        pc_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_now("rst_core", 1, 0, 0, 0, 0, 0, 32'h0);
            tick();
        end
        expect_now("run_first", 0, 1, 0, 0, 0, 1, 32'h0);
    endtask

    // One RUN cycle: check the running snapshot, present a PC sample, advance.
    task automatic drive(input logic v, input logic [31:0] p, input int cc_exp);
        expect_now("run", 0, 1, 0, 0, 0, cc_exp, 32'h0);
        pc_valid = v;
        pc       = p;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        pc       = '0;
        pc_valid = 1'b0;
        tick();
        tick();
        expect_now("reset_state", 1, 0, 0, 0, 0, 0, 32'h0);
        reset = 1'b0;
        tick();
        expect_now("idle", 1, 0, 0, 0, 0, 0, 32'h0);
        tick();

        // Halt on the third consecutive 8.
        start_run();
        drive(1, 32'd0, 1);
        drive(1, 32'd4, 2);
        drive(1, 32'd8, 3);
        drive(1, 32'd8, 4);
        drive(1, 32'd8, 5);
        pc_valid = 1'b0;
        expect_now("halt_pc8", 1, 0, 1, 1, 0, 5, 32'd8);
        tick();
        expect_now("done_hold", 1, 0, 1, 1, 0, 5, 32'd8);
        tick();

        // Restart from DONE; incrementing PC runs into the cycle limit, start mid-run ignored.
        start_run();
        for (int k = 1; k <= 25; k++) begin
            start = (k == 10);
            drive(1, 32'(4 * (k - 1)), k);
        end
        start    = 1'b0;
        pc_valid = 1'b0;
        expect_now("timeout", 1, 0, 1, 0, 1, 25, 32'h0);
        tick();

        // Halt completes on the same cycle the limit is reached: halt wins.
        start_run();
        for (int k = 1; k <= 25; k++) begin
            drive(1, (k <= 22) ? 32'(4 * (k - 1)) : 32'd88, k);
        end
        pc_valid = 1'b0;
        expect_now("halt_beats_timeout", 1, 0, 1, 1, 0, 25, 32'd88);
        tick();

        // Invalid samples between repeats neither break nor advance the streak.
        start_run();
        drive(1, 32'd8, 1);
        drive(0, 32'd100, 2);
        drive(1, 32'd8, 3);
        drive(0, 32'd12, 4);
        drive(1, 32'd8, 5);
        pc_valid = 1'b0;
        expect_now("halt_gaps", 1, 0, 1, 1, 0, 5, 32'd8);
        tick();

        // Changing PC restarts the streak: 8,8,12,8 must not halt.
        start_run();
        drive(1, 32'd8, 1);
        drive(1, 32'd8, 2);
        drive(1, 32'd12, 3);
        drive(1, 32'd8, 4);
        drive(1, 32'd16, 5);

        // Asynchronous reset in the tenth RUN cycle.
        for (int k = 6; k <= 9; k++) begin
            drive(1, 32'(4 * k + 16), k);
        end
        reset = 1'b1;
        expect_now("async_reset", 1, 0, 0, 0, 0, 0, 32'h0);
        tick();
        expect_now("reset_hold", 1, 0, 0, 0, 0, 0, 32'h0);
        reset    = 1'b0;
        pc_valid = 1'b0;
        tick();
        expect_now("idle_after_reset", 1, 0, 0, 0, 0, 0, 32'h0);
        tick();

        start_run();
        drive(1, 32'd0, 1);
        drive(1, 32'd4, 2);
        pc_valid = 1'b0;
        expect_now("rerun_cc3", 0, 1, 0, 0, 0, 3, 32'h0);
        tick();
        tick();

        while (stamp_q.size() > 0) begin
            void'(stamp_q.pop_front());
            void'(exp_q.pop_front());
            errors++;
            $display("FAIL %s: expectation never checked", name_q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
